// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// A hit returns the line one cycle after the lookup. A miss asks the memory
// controller for the word, fills the line, then forwards the word.
module icache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_done,
    output logic [31:0] if_inst,
    output logic        mc_valid,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_inst,
    input  logic        jump_flag
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;

    logic [0:0]          state;
    logic [LINES-1:0]    line_valid;
    logic [TAG_BITS-1:0] line_tag  [LINES];
    logic [31:0]         line_data [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_pc_bits;

    assign req_idx  = if_pc[INDEX_BITS+1:2];
    assign req_tag  = if_pc[31:INDEX_BITS+2];
    assign fill_idx = mc_addr[INDEX_BITS+1:2];
    assign fill_tag = mc_addr[31:INDEX_BITS+2];
    assign hit      = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    // A returning word is always written, even when a flush kills the request:
    // the data is correct for its address. Reset discards it.
    assign fill_en  = !rst && rdy && (state == MISS) && mc_done;

    // Drops in the mc_done cycle so the controller never starts a second read;
    // dropping on !rdy makes the controller abort and restart from byte 0.
    assign mc_valid = !rst && (state == MISS) && rdy && !mc_done && !jump_flag;

    assign unused_pc_bits = ^if_pc[1:0];

    // Tag/data storage: no reset needed, the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mc_inst;
        end
    end

    // Control: state, valid bits, request address and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_valid <= '0;
            if_done    <= 1'b0;
            if_inst    <= '0;
            mc_addr    <= '0;
        end else if (!rdy) begin
            if_done <= 1'b0;
        end else begin
            if_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_valid && !jump_flag) begin
                        if (hit) begin
                            if_done <= 1'b1;
                            if_inst <= line_data[req_idx];
                        end else begin
                            mc_addr <= if_pc;
                            state   <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_done) begin
                        line_valid[fill_idx] <= 1'b1;
                        state                <= IDLE;
                        if (!jump_flag) begin
                            if_done <= 1'b1;
                            if_inst <= mc_inst;
                        end
                    end else if (jump_flag) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios then randomized fetches, all checked
// against a line-level model (index -> cached pc) and a synthetic memory.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, if_valid, mc_done, jump_flag;
    logic [31:0] if_pc, mc_inst;
    logic        if_done, mc_valid;
    logic [31:0] if_inst, mc_addr;

    always #5 clk = ~clk;

    icache #(.INDEX_BITS(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_pc(if_pc),
        .if_done(if_done), .if_inst(if_inst),
        .mc_valid(mc_valid), .mc_addr(mc_addr),
        .mc_done(mc_done), .mc_inst(mc_inst),
        .jump_flag(jump_flag)
    );

    int checks   = 0;
    int failures = 0;

    // Model: which word address currently occupies each line.
    bit          m_valid [int];
    logic [31:0] m_pc    [int];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0000_0513;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid.exists(i) && (m_pc[i] == pc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch. lat: cycles the controller spends before mc_done;
    // stall: rdy-low cycles at the start of the miss;
    // kill: 0 none, 1 jump_flag instead of mc_done, 2 jump_flag with mc_done.
    task automatic fetch(input logic [31:0] pc, input int lat, input int stall, input int kill);
        bit h = model_hit(pc);
        if_valid = 1'b1;
        if_pc    = pc;
        @(negedge clk);
        chk("lookup_mc_valid", mc_valid, 0);
        tick();
        if (h) begin
            chk("hit_done", if_done, 1);
            chk("hit_inst", if_inst, mem_word(pc));
            if_valid = 1'b0;
            return;
        end
        chk("miss_no_done", if_done, 0);
        chk("miss_addr", mc_addr, pc);
        if (stall > 0) begin
            rdy = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_mc_valid", mc_valid, 0);
                tick();
                chk("stall_no_done", if_done, 0);
                chk("stall_addr", mc_addr, pc);
            end
            rdy = 1'b1;
        end
        repeat (lat) begin
            @(negedge clk);
            chk("miss_mc_valid", mc_valid, 1);
            chk("miss_addr_hold", mc_addr, pc);
            tick();
            chk("wait_no_done", if_done, 0);
        end
        if (kill == 1) begin
            jump_flag = 1'b1;
            if_valid  = 1'b0;
            @(negedge clk);
            chk("jump_mc_valid", mc_valid, 0);
            tick();
            jump_flag = 1'b0;
            chk("jump_no_done", if_done, 0);
            @(negedge clk);
            chk("jump_idle_mc_valid", mc_valid, 0);
            tick();
            chk("jump_no_done2", if_done, 0);
            return;
        end
        mc_done   = 1'b1;
        mc_inst   = mem_word(pc);
        jump_flag = (kill == 2);
        if (kill == 2) if_valid = 1'b0;
        @(negedge clk);
        chk("done_cycle_mc_valid", mc_valid, 0);
        tick();
        mc_done   = 1'b0;
        jump_flag = 1'b0;
        m_valid[idx_of(pc)] = 1'b1;
        m_pc[idx_of(pc)]    = pc;
        if (kill == 2) begin
            chk("jump_fill_no_done", if_done, 0);
        end else begin
            chk("fill_done", if_done, 1);
            chk("fill_inst", if_inst, mem_word(pc));
        end
        if_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; mc_done = 1'b0;
        jump_flag = 1'b0; if_pc = '0; mc_inst = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_done", if_done, 0);
        chk("rst_inst", if_inst, 0);
        chk("rst_addr", mc_addr, 0);
        chk("rst_mc_valid", mc_valid, 0);
        tick();
        rst = 1'b0;

        // Cold miss, re-fetch hit, conflict eviction.
        fetch(32'h0000_1000, 2, 0, 0);
        fetch(32'h0000_1000, 0, 0, 0);
        fetch(32'h0000_1400, 1, 0, 0);
        fetch(32'h0000_1000, 1, 0, 0);
        fetch(32'h0000_1000, 0, 0, 0);

        // Flush mid-miss (no fill), then flush with mc_done (fills).
        fetch(32'h0000_2000, 1, 0, 1);
        fetch(32'h0000_2000, 1, 0, 2);
        fetch(32'h0000_2000, 0, 0, 0);

        // Flush in IDLE swallows the lookup; the held request hits next cycle.
        if_valid = 1'b1; if_pc = 32'h0000_2000; jump_flag = 1'b1;
        @(negedge clk);
        chk("idle_jump_mc_valid", mc_valid, 0);
        tick();
        jump_flag = 1'b0;
        chk("idle_jump_no_done", if_done, 0);
        tick();
        chk("after_jump_hit_done", if_done, 1);
        chk("after_jump_hit_inst", if_inst, mem_word(32'h0000_2000));
        if_valid = 1'b0;

        // rdy low for three cycles mid-miss.
        fetch(32'h0000_3000, 2, 3, 0);

        // Reset mid-miss with a concurrent mc_done.
        if_valid = 1'b1; if_pc = 32'h0000_4000;
        tick();
        @(negedge clk);
        chk("pre_rst_mc_valid", mc_valid, 1);
        rst = 1'b1; mc_done = 1'b1; mc_inst = mem_word(32'h0000_4000);
        @(negedge clk);
        chk("rst_miss_mc_valid", mc_valid, 0);
        tick();
        rst = 1'b0; mc_done = 1'b0; if_valid = 1'b0;
        chk("rst_miss_done", if_done, 0);
        chk("rst_miss_inst", if_inst, 0);
        chk("rst_miss_addr", mc_addr, 0);
        m_valid.delete();
        m_pc.delete();
        fetch(32'h0000_2000, 1, 0, 0);
        fetch(32'h0000_4000, 1, 0, 0);

        // Random fetches over a small pool so hits, conflicts and kills mix.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            int lat, stall, kill, r;
            pc = 32'h4000_0000 + ($urandom_range(0, 3) * 1024) + ($urandom_range(0, 3) * 4);
            lat = $urandom_range(0, 3);
            stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            r = $urandom_range(0, 9);
            kill = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            fetch(pc, lat, stall, kill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
